imu_time_aligner: RTL and testbench

//  Downstream consumer of the IMU timestamp FIFO. Pops {imu_data, sys_time} entries and, per query time
//  (e.g. camera frame stamp), returns the bracketing IMU pair: last sample with time < query ("before"),

---
 rtl/imu_time_aligner_if.sv | 40 ++++
 rtl/imu_time_aligner.sv | 130 +++++++++++++
 tb/tb_imu_time_aligner.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/imu_time_aligner_if.sv
// Query, FIFO-read and result signals between imu_time_aligner and its neighbours.
// IMU_ALIGN_DELTA_EN adds the two query-relative delta outputs.
interface imu_time_aligner_if;
    logic         query_valid;
    logic [63:0]  query_time;
    logic         query_ready;
    logic         buf_empty;
    logic         buf_rd_en;
    logic [127:0] buf_data;
    logic         buf_valid;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_imu_before;
    logic [63:0]  out_time_before;
    logic [63:0]  out_imu_after;
    logic [63:0]  out_time_after;
    logic [2:0]   out_status;
`ifdef IMU_ALIGN_DELTA_EN
    logic [63:0]  out_delta_before;
    logic [63:0]  out_delta_after;
`endif

    modport slave (
        input  query_valid, query_time, buf_empty, buf_data, buf_valid, out_ready,
        output query_ready, buf_rd_en, out_valid, out_imu_before, out_time_before,
               out_imu_after, out_time_after, out_status
`ifdef IMU_ALIGN_DELTA_EN
        , output out_delta_before, out_delta_after
`endif
    );

    modport master (
        output query_valid, query_time, buf_empty, buf_data, buf_valid, out_ready,
        input  query_ready, buf_rd_en, out_valid, out_imu_before, out_time_before,
               out_imu_after, out_time_after, out_status
`ifdef IMU_ALIGN_DELTA_EN
        , input out_delta_before, out_delta_after
`endif
    );
endinterface

// File: rtl/imu_time_aligner.sv
// Finds the IMU samples bracketing a query time by popping the timestamp FIFO through a lookahead register.
// Optional feature macro: IMU_ALIGN_DELTA_EN (query-relative delta outputs).
module imu_time_aligner #(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1),
    parameter logic [63:0] MAX_GAP        = 64'd10000
) (
    input logic               clk,
    input logic               rst,
    imu_time_aligner_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT, OUT} state_t;

    state_t                state, state_nxt;
    logic [63:0]           q_time;
    logic [127:0]          prev, la;
    logic                  prev_valid, la_valid;
    logic [TO_WIDTH-1:0]   to_cnt;
    logic                  la_hit, timeout, load_out, after_ok;
    logic                  rd_en, qry_rdy;

    logic                  out_valid_r;
    logic [127:0]          out_before, out_after;
    logic [2:0]            status_r;
`ifdef IMU_ALIGN_DELTA_EN
    logic [63:0]           delta_before_r, delta_after_r;
`endif

    function automatic logic gap_exceeds(input logic [63:0] t_after, input logic [63:0] t_before);
        return (t_after - t_before) > MAX_GAP;
    endfunction

    function automatic logic [63:0] delta_of(input logic [63:0] a, input logic [63:0] b, input logic ok);
        return ok ? (a - b) : 64'd0;
    endfunction

    assign la_hit   = la_valid && (la[63:0] >= q_time);
    assign timeout  = bus.buf_empty && (to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));
    // Results are captured on the transition into OUT; only a CHECK hit carries an "after" sample.
    assign load_out = (state_nxt == OUT) && (state != OUT);
    assign after_ok = (state == CHECK);

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        qry_rdy   = 1'b0;
        case (state)
            IDLE: begin
                qry_rdy = 1'b1;
                if (bus.query_valid) state_nxt = CHECK;
            end
            CHECK: state_nxt = la_hit ? OUT : REQ;
            REQ: begin
                if (!bus.buf_empty) begin
                    rd_en     = 1'b1;
                    state_nxt = WAIT;
                end else if (timeout) begin
                    state_nxt = OUT;
                end
            end
            WAIT: if (bus.buf_valid) state_nxt = CHECK;
            OUT:  if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            q_time         <= '0;
            prev           <= '0;
            prev_valid     <= 1'b0;
            la             <= '0;
            la_valid       <= 1'b0;
            to_cnt         <= '0;
            out_valid_r    <= 1'b0;
            out_before     <= '0;
            out_after      <= '0;
            status_r       <= '0;
`ifdef IMU_ALIGN_DELTA_EN
            delta_before_r <= '0;
            delta_after_r  <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (bus.query_valid) begin
                    q_time <= bus.query_time;
                    to_cnt <= '0;
                end
                CHECK: if (!la_hit && la_valid) begin
                    prev       <= la;
                    prev_valid <= 1'b1;
                    la_valid   <= 1'b0;
                end
                REQ:  if (bus.buf_empty) to_cnt <= to_cnt + TO_WIDTH'(1);
                WAIT: if (bus.buf_valid) begin
                    la       <= bus.buf_data;
                    la_valid <= 1'b1;
                end
                OUT:  if (bus.out_ready) out_valid_r <= 1'b0;
                default: ;
            endcase
            if (load_out) begin
                out_valid_r <= 1'b1;
                out_before  <= prev;
                out_after   <= after_ok ? la : 128'd0;
                status_r    <= {prev_valid && after_ok && gap_exceeds(la[63:0], prev[63:0]),
                                after_ok, prev_valid};
`ifdef IMU_ALIGN_DELTA_EN
                delta_before_r <= delta_of(q_time, prev[63:0], prev_valid);
                delta_after_r  <= delta_of(la[63:0], q_time, after_ok);
`endif
            end
        end
    end

    assign bus.query_ready     = qry_rdy;
    assign bus.buf_rd_en       = rd_en;
    assign bus.out_valid       = out_valid_r;
    assign bus.out_imu_before  = out_before[127:64];
    assign bus.out_time_before = out_before[63:0];
    assign bus.out_imu_after   = out_after[127:64];
    assign bus.out_time_after  = out_after[63:0];
    assign bus.out_status      = status_r;
`ifdef IMU_ALIGN_DELTA_EN
    assign bus.out_delta_before = delta_before_r;
    assign bus.out_delta_after  = delta_after_r;
`endif
endmodule

// File: tb/tb_imu_time_aligner.sv
// Bench for imu_time_aligner: FIFO model, vector table with scoreboard queue, hand sequences for
// timeout, gap boundary, back-pressure and reset-during-read.
module tb_imu_time_aligner;
    typedef struct {
        logic [63:0] q;
        logic [63:0] tb;
        logic [63:0] ta;
        logic [2:0]  st;
        int          lat;
        int          pops;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imu_time_aligner_if bus();
    imu_time_aligner #(.TIMEOUT_CYCLES(8), .MAX_GAP(64'd10000)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    vec_t sb[$];

    logic [63:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;

    function automatic logic [63:0] imu_of(input logic [63:0] t);
        return t ^ 64'hC0DE_5A5A_0000_0000;
    endfunction

    always @(posedge clk) begin : fifo_model
        bus.buf_valid <= 1'b0;
        if (bus.buf_rd_en && rd_ptr < wr_ptr) begin
            bus.buf_data  <= {imu_of(mem[rd_ptr]), mem[rd_ptr]};
            bus.buf_valid <= 1'b1;
            rd_ptr        <= rd_ptr + 1;
            pop_cnt       <= pop_cnt + 1;
            bus.buf_empty <= (rd_ptr + 1 >= wr_ptr);
        end else begin
            bus.buf_empty <= (rd_ptr >= wr_ptr);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_fifo(input logic [63:0] t);
        mem[wr_ptr] = t;
        wr_ptr++;
    endtask

    task automatic do_reset();
        wr_ptr = rd_ptr;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_query(input vec_t v, input int hold);
        vec_t e;
        int lat;
        int start;
        logic [63:0] tb_seen;
        logic [2:0]  st_seen;
        sb.push_back(v);
        start = pop_cnt;
        bus.query_valid = 1'b1;
        bus.query_time  = v.q;
        @(negedge clk);
        bus.query_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        if (!bus.out_valid) begin
            total++;
            bad++;
            $display("FAIL out_valid_wait q=%0d actual=no result expected=result", e.q);
            return;
        end
        chk("latency", 64'(lat), 64'(e.lat));
        chk("pops", 64'(pop_cnt - start), 64'(e.pops));
        chk("time_before", bus.out_time_before, e.tb);
        chk("imu_before", bus.out_imu_before, e.st[0] ? imu_of(e.tb) : 64'd0);
        chk("time_after", bus.out_time_after, e.ta);
        chk("imu_after", bus.out_imu_after, e.st[1] ? imu_of(e.ta) : 64'd0);
        chk("status", 64'(bus.out_status), 64'(e.st));
        chk("query_ready_out", 64'(bus.query_ready), 64'd0);
`ifdef IMU_ALIGN_DELTA_EN
        chk("delta_before", bus.out_delta_before, e.st[0] ? e.q - e.tb : 64'd0);
        chk("delta_after", bus.out_delta_after, e.st[1] ? e.ta - e.q : 64'd0);
`endif
        tb_seen = bus.out_time_before;
        st_seen = bus.out_status;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_time_before", bus.out_time_before, tb_seen);
            chk("hold_status", 64'(bus.out_status), 64'(st_seen));
            chk("hold_rd_en", 64'(bus.buf_rd_en), 64'd0);
            chk("hold_query_ready", 64'(bus.query_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("accept_valid", 64'(bus.out_valid), 64'd0);
        chk("accept_query_ready", 64'(bus.query_ready), 64'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t tbl [5];
        vec_t v;
        int n;
        tbl[0] = '{q: 64'd250,   tb: 64'd200,   ta: 64'd300,   st: 3'b011, lat: 10, pops: 3};
        tbl[1] = '{q: 64'd300,   tb: 64'd200,   ta: 64'd300,   st: 3'b011, lat: 1,  pops: 0};
        tbl[2] = '{q: 64'd301,   tb: 64'd300,   ta: 64'd20400, st: 3'b111, lat: 4,  pops: 1};
        tbl[3] = '{q: 64'd30000, tb: 64'd20400, ta: 64'd0,     st: 3'b001, lat: 9,  pops: 0};
        tbl[4] = '{q: 64'd30000, tb: 64'd20400, ta: 64'd0,     st: 3'b001, lat: 9,  pops: 0};

        bus.query_valid = 1'b0;
        bus.query_time  = '0;
        bus.out_ready   = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_query_ready", 64'(bus.query_ready), 64'd1);
        chk("rst_rd_en", 64'(bus.buf_rd_en), 64'd0);
        chk("rst_status", 64'(bus.out_status), 64'd0);
        chk("rst_time_before", bus.out_time_before, 64'd0);
        chk("rst_time_after", bus.out_time_after, 64'd0);
        rst = 1'b0;

        push_fifo(64'd100); push_fifo(64'd200); push_fifo(64'd300); push_fifo(64'd20400);
        @(negedge clk);
        for (int i = 0; i < 5; i++) run_query(tbl[i], 0);

        // Empty FIFO with no lookahead: timeout with nothing found.
        do_reset();
        v = '{q: 64'd50, tb: 64'd0, ta: 64'd0, st: 3'b000, lat: 9, pops: 0};
        run_query(v, 0);

        // Gap exactly MAX_GAP is not an error.
        do_reset();
        push_fifo(64'd100); push_fifo(64'd10100);
        @(negedge clk);
        v = '{q: 64'd150, tb: 64'd100, ta: 64'd10100, st: 3'b011, lat: 7, pops: 2};
        run_query(v, 0);

        // Back-pressure with a non-empty FIFO behind the result.
        do_reset();
        push_fifo(64'd100); push_fifo(64'd200); push_fifo(64'd999);
        @(negedge clk);
        v = '{q: 64'd150, tb: 64'd100, ta: 64'd200, st: 3'b011, lat: 7, pops: 2};
        run_query(v, 5);

        // Reset while the pop of 999 is in flight; that entry must be lost.
        bus.query_valid = 1'b1;
        bus.query_time  = 64'd1000;
        @(negedge clk);
        bus.query_valid = 1'b0;
        n = 0;
        while (!bus.buf_rd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rd_en_seen", 64'(bus.buf_rd_en), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("wait_rst_query_ready", 64'(bus.query_ready), 64'd1);
        chk("wait_rst_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("wait_rst_idle_rd_en", 64'(bus.buf_rd_en), 64'd0);
        push_fifo(64'd2000);
        @(negedge clk);
        v = '{q: 64'd500, tb: 64'd0, ta: 64'd2000, st: 3'b010, lat: 4, pops: 1};
        run_query(v, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
